// File: rtl/os_clk_sequencer_pkg.sv
// Shared types and defaults for the os_clk_sequencer reset/clock-enable block.
// Exports: state_t, default NCO/settle/prime constants, cnt_w() width helper.
package os_clk_pkg;

  typedef enum logic [1:0] {
    SYNC,
    SETTLE,
    PRIME,
    RUN
  } state_t;

  localparam int OS_NCO_INC     = 10;
  localparam int OS_NCO_MOD     = 324;
  localparam int OS_SETTLE      = 64800;
  localparam int OS_RESET_TICKS = 8;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/os_clk_sequencer_if.sv
// Control/status bundle of os_clk_sequencer.
// slave: soft_rst, hold in; sys_reset_n, cpu_ce, ph2, ready out. master: mirror.
interface os_clk_sequencer_if;

  logic soft_rst;
  logic hold;
  logic sys_reset_n;
  logic cpu_ce;
  logic ph2;
  logic ready;

  modport master (
    output soft_rst,
    output hold,
    input  sys_reset_n,
    input  cpu_ce,
    input  ph2,
    input  ready
  );

  modport slave (
    input  soft_rst,
    input  hold,
    output sys_reset_n,
    output cpu_ce,
    output ph2,
    output ready
  );

endinterface

// File: rtl/os_clk_sequencer_nco.sv
// Fractional NCO: phi2 phase toggle and cpu clock-enable from the fast clock.
// Ports: clk, reset_n, run in; tick (phase edge), ph2 (level), ce (ph2 fall) out.
module os_nco #(
  parameter int INC = 10,
  parameter int MOD = 324
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tick,
  output logic ph2,
  output logic ce
);

  localparam int W = $clog2(MOD + INC);
  localparam logic [W-1:0] INC_W = W'(INC);
  localparam logic [W-1:0] MOD_W = W'(MOD);

  logic [W-1:0] acc;
  logic [W-1:0] sum;
  logic         wrap;

  always_comb begin
    sum  = acc + INC_W;
    wrap = (sum >= MOD_W);
  end

  // Holding run low freezes acc and ph2 so timing resumes in phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      tick <= 1'b0;
      ph2  <= 1'b0;
      ce   <= 1'b0;
    end else if (run) begin
      tick <= wrap;
      ce   <= wrap & ph2;
      if (wrap) begin
        acc <= sum - MOD_W;
        ph2 <= ~ph2;
      end else begin
        acc <= sum;
      end
    end else begin
      tick <= 1'b0;
      ce   <= 1'b0;
    end
  end

endmodule

// File: rtl/os_clk_sequencer.sv
// Power-up reset sequencer and CPU timebase: sync, settle, prime, run.
// Ports: clk, reset_n (async low); bus.slave = soft_rst, hold / sys_reset_n, cpu_ce, ph2, ready.
module os_clk_sequencer
  import os_clk_pkg::*;
#(
  parameter int SETTLE_CYCLES = OS_SETTLE,
  parameter int RESET_TICKS   = OS_RESET_TICKS,
  parameter int NCO_INC       = OS_NCO_INC,
  parameter int NCO_MOD       = OS_NCO_MOD
) (
  input  logic               clk,
  input  logic               reset_n,
  os_clk_sequencer_if.slave  bus
);

  if (!(NCO_INC > 0 && NCO_INC < NCO_MOD &&
        RESET_TICKS >= 1 && SETTLE_CYCLES >= 1)) begin : g_bad_cfg
    $fatal(1, "os_clk_sequencer: illegal parameters");
  end

  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam int TW = cnt_w(RESET_TICKS);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(RESET_TICKS - 1);

  state_t        state;
  state_t        state_d;
  logic [1:0]    sync_q;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic          settle_done;
  logic          prime_done;
  logic          run;
  logic          tick;
  logic          ph2;
  logic          ce;
  logic          fall;
  logic          srn_d;
  logic          rdy_d;
  logic          srn_q;
  logic          rdy_q;

  // Async assert, sync deassert of the button/POR reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign run  = ((state == PRIME) || (state == RUN)) & ~bus.hold;
  assign fall = tick & ~ph2;

  os_nco #(
    .INC (NCO_INC),
    .MOD (NCO_MOD)
  ) u_nco (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .tick    (tick),
    .ph2     (ph2),
    .ce      (ce)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SYNC;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    settle_done = (scnt == S_LAST);
    prime_done  = (tcnt == T_LAST);
    state_d     = state;
    unique case (state)
      SYNC:   if (sync_q[1]) state_d = SETTLE;
      SETTLE: if (settle_done) state_d = PRIME;
      PRIME:  if (!bus.soft_rst && fall && prime_done) state_d = RUN;
      RUN:    if (bus.soft_rst) state_d = PRIME;
    endcase
  end

  // Outputs are registered from the next state so they change on entry.
  always_comb begin
    srn_d = (state_d == RUN);
    rdy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srn_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      srn_q <= srn_d;
      rdy_q <= rdy_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scnt <= '0;
    end else if (state == SETTLE) begin
      scnt <= settle_done ? '0 : scnt + 1'b1;
    end else begin
      scnt <= '0;
    end
  end

  // A pending soft reset keeps the prime count pinned at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (state == PRIME && !bus.soft_rst) begin
      if (fall) begin
        tcnt <= prime_done ? '0 : tcnt + 1'b1;
      end
    end else begin
      tcnt <= '0;
    end
  end

  assign bus.sys_reset_n = srn_q;
  assign bus.ready       = rdy_q;
  assign bus.cpu_ce      = ce;
  assign bus.ph2         = ph2;

endmodule

// File: tb/tb_os_clk_sequencer.sv
// Directed self-checking bench for os_clk_sequencer with a small scoreboard.
// Small settle/prime parameters keep the boot sequence short.
module tb_os_clk_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  os_clk_sequencer_if bus ();

  int total = 0;
  int bad = 0;
  int ce_q[$];
  int rise_q[$];

  always #5 clk = ~clk;

  os_clk_sequencer #(
    .SETTLE_CYCLES (100),
    .RESET_TICKS   (2),
    .NCO_INC       (10),
    .NCO_MOD       (324)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " sys_reset_n"}, bus.sys_reset_n, 0);
    chk({tag, " cpu_ce"}, bus.cpu_ce, 0);
    chk({tag, " ph2"}, bus.ph2, 0);
    chk({tag, " ready"}, bus.ready, 0);
  endtask

  // Release reset between edges. Edge 1/2: synchroniser, edge 3: SETTLE,
  // edge 103: PRIME (acc=0). Ticks at +33 (ph2 up), +65 (ce), +98, +130 (ce),
  // so cpu_ce at edges 168 and 233 and RUN on edge 234.
  task automatic boot(input string tag);
    int n;
    bit done;
    bit early;
    n = 0;
    done = 0;
    early = 0;
    reset_n = 1'b1;
    ce_q.push_back(168);
    ce_q.push_back(233);
    rise_q.push_back(234);
    while (!done && n < 400) begin
      step();
      n++;
      if (bus.ready === 1'b1 && bus.sys_reset_n !== 1'b1) early = 1;
      if (bus.cpu_ce === 1'b1) begin
        chk({tag, " ce_expected"}, ce_q.size() != 0, 1);
        if (ce_q.size() != 0) chk({tag, " ce_edge"}, n, ce_q.pop_front());
      end
      if (bus.sys_reset_n === 1'b1) begin
        chk({tag, " run_edge"}, n, rise_q.pop_front());
        chk({tag, " ready_with_run"}, bus.ready, 1);
        done = 1;
      end
    end
    chk({tag, " boot_done"}, done, 1);
    chk({tag, " ce_left"}, ce_q.size(), 0);
    chk({tag, " ready_early"}, early, 0);
    ce_q.delete();
    rise_q.delete();
  endtask

  task automatic wait_ce(input string tag, input int limit, output int n);
    bit seen;
    seen = 0;
    n = 0;
    while (!seen && n < limit) begin
      step();
      n++;
      if (bus.cpu_ce === 1'b1) seen = 1;
    end
    chk({tag, " ce_found"}, seen, 1);
  endtask

  initial begin
    int ces;
    int last;
    int gap_bad;
    int hi_start;
    int hi_bad;
    int coin_bad;
    int n;
    int held_ce;
    int ph_chg;
    int srn_hi;
    int rdy_hi;
    logic prev_ph2;
    logic prev_ce;
    logic ph_ref;
    bit done;

    bus.soft_rst = 1'b0;
    bus.hold = 1'b0;
    reset_n = 1'b0;
    repeat (10) step();
    chk_zero("reset");

    boot("t1");

    ces = 0;
    last = -1;
    gap_bad = 0;
    hi_start = -1;
    hi_bad = 0;
    coin_bad = 0;
    prev_ph2 = bus.ph2;
    for (int i = 1; i <= 3240; i++) begin
      step();
      if (bus.cpu_ce === 1'b1) begin
        ces++;
        if (last >= 0 && !((i - last) inside {64, 65})) gap_bad++;
        last = i;
        if (!(prev_ph2 === 1'b1 && bus.ph2 === 1'b0)) coin_bad++;
      end
      if (bus.ph2 === 1'b1 && prev_ph2 === 1'b0) hi_start = i;
      if (bus.ph2 === 1'b0 && prev_ph2 === 1'b1 && hi_start >= 0)
        if (!((i - hi_start) inside {32, 33})) hi_bad++;
      prev_ph2 = bus.ph2;
    end
    chk("t2 ce_count", ces, 50);
    chk("t2 ce_gap", gap_bad, 0);
    chk("t2 ph2_high", hi_bad, 0);
    chk("t2 ce_on_fall", coin_bad, 0);

    wait_ce("t3", 100, n);
    bus.soft_rst = 1'b1;
    step();
    chk("t3 srn_low", bus.sys_reset_n, 0);
    chk("t3 ready_low", bus.ready, 0);
    bus.soft_rst = 1'b0;
    ces = 0;
    n = 0;
    done = 0;
    prev_ce = 1'b0;
    while (!done && n < 200) begin
      prev_ce = bus.cpu_ce;
      step();
      n++;
      if (bus.cpu_ce === 1'b1) ces++;
      if (bus.sys_reset_n === 1'b1) done = 1;
    end
    chk("t3 rerun", done, 1);
    chk("t3 ce_count", ces, 2);
    chk("t3 no_settle", n <= 135, 1);
    chk("t3 run_after_ce", prev_ce, 1);
    chk("t3 ready", bus.ready, 1);

    wait_ce("t4", 100, n);
    repeat (10) step();
    bus.hold = 1'b1;
    ph_ref = bus.ph2;
    held_ce = 0;
    ph_chg = 0;
    repeat (300) begin
      step();
      if (bus.cpu_ce !== 1'b0) held_ce++;
      if (bus.ph2 !== ph_ref) ph_chg++;
    end
    bus.hold = 1'b0;
    chk("t4 held_ce", held_ce, 0);
    chk("t4 ph2_frozen", ph_chg, 0);
    wait_ce("t4 resume", 100, n);
    chk("t4 phase_cont", (10 + n) inside {64, 65}, 1);

    step();
    #3;
    reset_n = 1'b0;
    #1;
    chk_zero("t5 async");
    repeat (5) step();
    boot("t5");

    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (110) step();
    bus.soft_rst = 1'b1;
    bus.hold = 1'b1;
    held_ce = 0;
    srn_hi = 0;
    rdy_hi = 0;
    repeat (500) begin
      step();
      if (bus.cpu_ce !== 1'b0) held_ce++;
      if (bus.sys_reset_n !== 1'b0) srn_hi++;
      if (bus.ready !== 1'b0) rdy_hi++;
    end
    chk("t6 no_ce", held_ce, 0);
    chk("t6 srn_low", srn_hi, 0);
    chk("t6 ready_low", rdy_hi, 0);
    bus.soft_rst = 1'b0;
    bus.hold = 1'b0;
    ces = 0;
    n = 0;
    done = 0;
    while (!done && n < 250) begin
      step();
      n++;
      if (bus.cpu_ce === 1'b1) ces++;
      if (bus.sys_reset_n === 1'b1) done = 1;
    end
    chk("t6 rerun", done, 1);
    chk("t6 ce_count", ces, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
